// File: rtl/game_frame_sequencer_pkg.sv
// Shared state encoding and state-decode helpers for the game frame sequencer
// and the datapath mux logic that follows its state.
package game_frame_sequencer_pkg;

  typedef enum logic [3:0] {
    S_INIT          = 4'd0,
    S_IDLE          = 4'd1,
    S_GEN_MOVE      = 4'd2,
    S_CHECK_COLLIDE = 4'd3,
    S_LINK_ACTION   = 4'd4,
    S_MOVE_ENEMY    = 4'd5,
    S_DRAW_MAP      = 4'd6,
    S_DRAW_LINK     = 4'd7,
    S_DRAW_ENEMY    = 4'd8,
    S_DRAW_VGA      = 4'd9
  } state_t;

  // States that wait on the datapath start/done handshake.
  function automatic logic is_handshake(input state_t s);
    case (s)
      S_GEN_MOVE, S_CHECK_COLLIDE, S_MOVE_ENEMY,
      S_DRAW_MAP, S_DRAW_LINK, S_DRAW_ENEMY, S_DRAW_VGA: return 1'b1;
      default:                                           return 1'b0;
    endcase
  endfunction

  // States that iterate over the alive enemy slots.
  function automatic logic is_enemy_state(input state_t s);
    return (s == S_MOVE_ENEMY) || (s == S_DRAW_ENEMY);
  endfunction

endpackage

// File: rtl/game_frame_sequencer_enemy_iter.sv
// Combinational enemy slot iterator: finds the lowest set bit of the mask
// (first=1) or the lowest set bit strictly above cur (first=0).
module game_frame_sequencer_enemy_iter #(
  parameter int unsigned NUM_ENEMIES = 4,
  parameter int unsigned IDX_W       = 2
) (
  input  logic [NUM_ENEMIES-1:0] mask,
  input  logic                   first,
  input  logic [IDX_W-1:0]       cur,
  output logic [IDX_W-1:0]       next_idx,
  output logic                   found
);

  // Priority scan from slot 0 upward; next_idx stays 0 when nothing qualifies.
  always_comb begin
    next_idx = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < NUM_ENEMIES; i++) begin
      if (!found && mask[i] && (first || (i > 32'(cur)))) begin
        found    = 1'b1;
        next_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/game_frame_sequencer.sv
// Top-level game frame sequencer: walks one frame through move, collide,
// Link action, per-enemy move, draw passes and VGA flush, with pause mode,
// a per-stage watchdog and sticky timeout/overrun flags.
module game_frame_sequencer
  import game_frame_sequencer_pkg::*;
#(
  parameter int unsigned NUM_ENEMIES    = 4,
  parameter int unsigned IDX_W          = 2,
  parameter int unsigned FRAME_W        = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   frame_tick,
  input  logic                   pause,
  input  logic [NUM_ENEMIES-1:0] alive_mask,
  input  logic                   stage_done,
  input  logic                   err_clear,
  output logic [3:0]             state,
  output logic                   stage_start,
  output logic [IDX_W-1:0]       enemy_idx,
  output logic                   busy,
  output logic [FRAME_W-1:0]     frame_count,
  output logic                   timeout_err,
  output logic                   overrun_err
);

  localparam bit          WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam int unsigned WD_W    = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_EN ? TIMEOUT_CYCLES - 1 : 0);

  state_t                 state_q, state_d;
  logic                   start_q, start_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_ENEMIES-1:0] snap_q;
  logic [WD_W-1:0]        wd_q;
  logic [FRAME_W-1:0]     fc_q;
  logic                   to_err_q, ov_err_q;
  logic                   snap_load, frame_inc;
  logic                   hs_now, enemy_now, mask_empty, live;
  logic                   timeout_hit, advance, overrun_hit;
  logic [IDX_W-1:0]       iter_next;
  logic                   iter_found;

  assign hs_now      = is_handshake(state_q);
  assign enemy_now   = is_enemy_state(state_q);
  assign mask_empty  = (snap_q == '0);
  // A stage listens for done only after its start cycle; an empty enemy pass never listens.
  assign live        = hs_now && !start_q && !(enemy_now && mask_empty);
  assign timeout_hit = WD_EN && live && !stage_done && (wd_q >= WD_LAST);
  assign advance     = live && (stage_done || timeout_hit);
  assign overrun_hit = frame_tick && (state_q != S_IDLE);

  // Outside the enemy states the iterator looks ahead for the first slot of the coming pass.
  game_frame_sequencer_enemy_iter #(
    .NUM_ENEMIES (NUM_ENEMIES),
    .IDX_W       (IDX_W)
  ) u_enemy_iter (
    .mask     (snap_q),
    .first    (!enemy_now),
    .cur      (idx_q),
    .next_idx (iter_next),
    .found    (iter_found)
  );

  // Next-state, next stage_start pulse, next enemy index and frame bookkeeping strobes.
  always_comb begin
    state_d   = state_q;
    start_d   = 1'b0;
    idx_d     = '0;
    snap_load = 1'b0;
    frame_inc = 1'b0;
    case (state_q)
      S_INIT: begin
        state_d   = S_DRAW_MAP;
        start_d   = 1'b1;
        snap_load = 1'b1;
      end
      S_IDLE: begin
        if (frame_tick) begin
          snap_load = 1'b1;
          start_d   = 1'b1;
          if (pause) begin
            state_d = S_DRAW_MAP;
          end else begin
            state_d   = S_GEN_MOVE;
            frame_inc = 1'b1;
          end
        end
      end
      S_GEN_MOVE: begin
        if (advance) begin
          state_d = S_CHECK_COLLIDE;
          start_d = 1'b1;
        end
      end
      S_CHECK_COLLIDE: begin
        if (advance) begin
          state_d = S_LINK_ACTION;
          start_d = 1'b1;
        end
      end
      S_LINK_ACTION: begin
        state_d = S_MOVE_ENEMY;
        start_d = iter_found;
        idx_d   = iter_next;
      end
      S_MOVE_ENEMY, S_DRAW_ENEMY: begin
        idx_d = idx_q;
        if (mask_empty || (advance && !iter_found)) begin
          state_d = (state_q == S_MOVE_ENEMY) ? S_DRAW_MAP : S_DRAW_VGA;
          start_d = 1'b1;
          idx_d   = '0;
        end else if (advance) begin
          idx_d   = iter_next;
          start_d = 1'b1;
        end
      end
      S_DRAW_MAP: begin
        if (advance) begin
          state_d = S_DRAW_LINK;
          start_d = 1'b1;
        end
      end
      S_DRAW_LINK: begin
        if (advance) begin
          state_d = S_DRAW_ENEMY;
          start_d = iter_found;
          idx_d   = iter_next;
        end
      end
      S_DRAW_VGA: begin
        if (advance) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with stage_start pulse, enemy index, alive snapshot and frame counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_INIT;
      start_q <= 1'b0;
      idx_q   <= '0;
      snap_q  <= '0;
      fc_q    <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      idx_q   <= idx_d;
      if (snap_load) snap_q <= alive_mask;
      if (frame_inc) fc_q   <= fc_q + 1'b1;
    end
  end

  // Watchdog restarts on every new stage or state change and counts while a handshake is pending.
  always_ff @(posedge clock) begin
    if (reset || !WD_EN) begin
      wd_q <= '0;
    end else if (start_d || (state_d != state_q)) begin
      wd_q <= '0;
    end else if (hs_now) begin
      wd_q <= wd_q + 1'b1;
    end
  end

  // Sticky error flags; a set in the same cycle as err_clear takes priority.
  always_ff @(posedge clock) begin
    if (reset) begin
      to_err_q <= 1'b0;
      ov_err_q <= 1'b0;
    end else begin
      if (timeout_hit)    to_err_q <= 1'b1;
      else if (err_clear) to_err_q <= 1'b0;
      if (overrun_hit)    ov_err_q <= 1'b1;
      else if (err_clear) ov_err_q <= 1'b0;
    end
  end

  assign state       = state_q;
  assign stage_start = start_q;
  assign enemy_idx   = idx_q;
  assign busy        = (state_q != S_IDLE);
  assign frame_count = fc_q;
  assign timeout_err = to_err_q;
  assign overrun_err = ov_err_q;

endmodule

// File: tb/tb_game_frame_sequencer.sv
// Directed self-checking bench for game_frame_sequencer (4 enemies, 3-bit
// frame counter so the wrap is reachable, 8-cycle watchdog).
module tb_game_frame_sequencer;

  logic       clock;
  logic       reset;
  logic       frame_tick;
  logic       pause;
  logic [3:0] alive_mask;
  logic       stage_done;
  logic       err_clear;
  logic [3:0] state;
  logic       stage_start;
  logic [1:0] enemy_idx;
  logic       busy;
  logic [2:0] frame_count;
  logic       timeout_err;
  logic       overrun_err;

  int checks = 0;
  int errors = 0;

  game_frame_sequencer #(
    .NUM_ENEMIES    (4),
    .IDX_W          (2),
    .FRAME_W        (3),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .pause       (pause),
    .alive_mask  (alive_mask),
    .stage_done  (stage_done),
    .err_clear   (err_clear),
    .state       (state),
    .stage_start (stage_start),
    .enemy_idx   (enemy_idx),
    .busy        (busy),
    .frame_count (frame_count),
    .timeout_err (timeout_err),
    .overrun_err (overrun_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock, then check state, stage_start, enemy_idx and busy.
  task automatic cyc(input logic [3:0] st, input logic ss, input logic [1:0] idx);
    @(posedge clock);
    #1;
    chk("state", 32'(state), 32'(st));
    chk("stage_start", 32'(stage_start), 32'(ss));
    chk("enemy_idx", 32'(enemy_idx), 32'(idx));
    chk("busy", 32'(busy), 32'(st != 4'd1));
  endtask

  // One handshake stage: entry cycle, one waiting cycle, then done for the next edge.
  task automatic hs(input logic [3:0] st, input logic [1:0] idx);
    cyc(st, 1'b1, idx);
    stage_done = 1'b0;
    cyc(st, 1'b0, idx);
    stage_done = 1'b1;
  endtask

  // Unpaused frame with alive mask 1010; optionally alter the mask during DRAW_LINK.
  task automatic frame_1010(input logic change);
    stage_done = 1'b0;
    alive_mask = 4'b1010;
    frame_tick = 1'b1;
    cyc(4'd2, 1'b1, 2'd0);
    frame_tick = 1'b0;
    cyc(4'd2, 1'b0, 2'd0);
    stage_done = 1'b1;
    hs(4'd3, 2'd0);
    cyc(4'd4, 1'b1, 2'd0);
    stage_done = 1'b0;
    hs(4'd5, 2'd1);
    hs(4'd5, 2'd3);
    hs(4'd6, 2'd0);
    cyc(4'd7, 1'b1, 2'd0);
    stage_done = 1'b0;
    if (change) alive_mask = 4'b1111;
    cyc(4'd7, 1'b0, 2'd0);
    stage_done = 1'b1;
    hs(4'd8, 2'd1);
    hs(4'd8, 2'd3);
    hs(4'd9, 2'd0);
    cyc(4'd1, 1'b0, 2'd0);
    stage_done = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && state != 4'd1; i++) begin
      @(posedge clock);
      #1;
    end
    chk("reach_idle", 32'(state), 32'd1);
  endtask

  initial begin
    reset      = 1'b1;
    frame_tick = 1'b0;
    pause      = 1'b0;
    alive_mask = 4'b0000;
    stage_done = 1'b0;
    err_clear  = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_stage_start", 32'(stage_start), 32'd0);
    chk("rst_enemy_idx", 32'(enemy_idx), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    chk("rst_overrun_err", 32'(overrun_err), 32'd0);

    // T1: empty mask, done held high
    reset      = 1'b0;
    stage_done = 1'b1;
    cyc(4'd6, 1'b1, 2'd0); cyc(4'd6, 1'b0, 2'd0);
    cyc(4'd7, 1'b1, 2'd0); cyc(4'd7, 1'b0, 2'd0);
    cyc(4'd8, 1'b0, 2'd0);
    cyc(4'd9, 1'b1, 2'd0); cyc(4'd9, 1'b0, 2'd0);
    cyc(4'd1, 1'b0, 2'd0);
    frame_tick = 1'b1;
    cyc(4'd2, 1'b1, 2'd0);
    frame_tick = 1'b0;
    cyc(4'd2, 1'b0, 2'd0);
    cyc(4'd3, 1'b1, 2'd0); cyc(4'd3, 1'b0, 2'd0);
    cyc(4'd4, 1'b1, 2'd0);
    cyc(4'd5, 1'b0, 2'd0);
    cyc(4'd6, 1'b1, 2'd0); cyc(4'd6, 1'b0, 2'd0);
    cyc(4'd7, 1'b1, 2'd0); cyc(4'd7, 1'b0, 2'd0);
    cyc(4'd8, 1'b0, 2'd0);
    cyc(4'd9, 1'b1, 2'd0); cyc(4'd9, 1'b0, 2'd0);
    cyc(4'd1, 1'b0, 2'd0);
    chk("t1_frame_count", 32'(frame_count), 32'd1);

    // T2: mask 1010, enemies 1 and 3 in both passes
    frame_1010(1'b0);
    chk("t2_frame_count", 32'(frame_count), 32'd2);

    // T3: mask widened mid-frame, snapshot still 1010
    frame_1010(1'b1);
    chk("t3_frame_count", 32'(frame_count), 32'd3);

    // T4: paused frame redraws only, enemy pass over fresh snapshot 0100
    alive_mask = 4'b0100;
    pause      = 1'b1;
    frame_tick = 1'b1;
    cyc(4'd6, 1'b1, 2'd0);
    frame_tick = 1'b0;
    cyc(4'd6, 1'b0, 2'd0);
    stage_done = 1'b1;
    hs(4'd7, 2'd0);
    hs(4'd8, 2'd2);
    hs(4'd9, 2'd0);
    cyc(4'd1, 1'b0, 2'd0);
    stage_done = 1'b0;
    pause      = 1'b0;
    chk("t4_frame_count", 32'(frame_count), 32'd3);

    // T5: watchdog in DRAW_MAP
    alive_mask = 4'b0000;
    pause      = 1'b1;
    frame_tick = 1'b1;
    cyc(4'd6, 1'b1, 2'd0);
    frame_tick = 1'b0;
    pause      = 1'b0;
    repeat (7) cyc(4'd6, 1'b0, 2'd0);
    chk("t5_timeout_before", 32'(timeout_err), 32'd0);
    cyc(4'd7, 1'b1, 2'd0);
    chk("t5_timeout_set", 32'(timeout_err), 32'd1);
    stage_done = 1'b1;
    cyc(4'd7, 1'b0, 2'd0);
    cyc(4'd8, 1'b0, 2'd0);
    cyc(4'd9, 1'b1, 2'd0); cyc(4'd9, 1'b0, 2'd0);
    cyc(4'd1, 1'b0, 2'd0);
    chk("t5_timeout_sticky", 32'(timeout_err), 32'd1);
    err_clear = 1'b1;
    cyc(4'd1, 1'b0, 2'd0);
    err_clear = 1'b0;
    chk("t5_timeout_cleared", 32'(timeout_err), 32'd0);
    chk("t5_frame_count", 32'(frame_count), 32'd3);

    // T6: tick during DRAW_VGA is dropped and flagged
    pause      = 1'b1;
    frame_tick = 1'b1;
    cyc(4'd6, 1'b1, 2'd0);
    frame_tick = 1'b0;
    pause      = 1'b0;
    stage_done = 1'b1;
    cyc(4'd6, 1'b0, 2'd0);
    cyc(4'd7, 1'b1, 2'd0); cyc(4'd7, 1'b0, 2'd0);
    cyc(4'd8, 1'b0, 2'd0);
    cyc(4'd9, 1'b1, 2'd0);
    chk("t6_overrun_before", 32'(overrun_err), 32'd0);
    frame_tick = 1'b1;
    cyc(4'd9, 1'b0, 2'd0);
    frame_tick = 1'b0;
    chk("t6_overrun_set", 32'(overrun_err), 32'd1);
    cyc(4'd1, 1'b0, 2'd0);
    cyc(4'd1, 1'b0, 2'd0);
    chk("t6_overrun_sticky", 32'(overrun_err), 32'd1);
    chk("t6_frame_count", 32'(frame_count), 32'd3);

    // Set wins over clear, then clear alone, then reset mid-CHECK_COLLIDE
    stage_done = 1'b0;
    frame_tick = 1'b1;
    cyc(4'd2, 1'b1, 2'd0);
    frame_tick = 1'b0;
    chk("t6_frame_count_inc", 32'(frame_count), 32'd4);
    cyc(4'd2, 1'b0, 2'd0);
    stage_done = 1'b1;
    cyc(4'd3, 1'b1, 2'd0);
    stage_done = 1'b0;
    chk("t6_overrun_cleared_pre", 32'(overrun_err), 32'd1);
    err_clear  = 1'b1;
    frame_tick = 1'b1;
    cyc(4'd3, 1'b0, 2'd0);
    frame_tick = 1'b0;
    chk("set_wins_clear", 32'(overrun_err), 32'd1);
    cyc(4'd3, 1'b0, 2'd0);
    err_clear = 1'b0;
    chk("clear_alone", 32'(overrun_err), 32'd0);
    reset = 1'b1;
    cyc(4'd0, 1'b0, 2'd0);
    chk("midframe_reset_fc", 32'(frame_count), 32'd0);
    reset = 1'b0;

    // Frame counter wrap at 3 bits
    stage_done = 1'b1;
    wait_idle(40);
    for (int f = 1; f <= 8; f++) begin
      frame_tick = 1'b1;
      @(posedge clock);
      #1;
      frame_tick = 1'b0;
      chk("wrap_enter", 32'(state), 32'd2);
      wait_idle(40);
      chk("wrap_frame_count", 32'(frame_count), 32'(f % 8));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
